rv_bus_fabric: RTL and testbench
================================

# rv_bus_fabric

Address decoder and transaction sequencer between the RISC-V core's native memory bus (valid/ready) and its two slaves: the dual-port shared RAM (RISC-V port) and a generic IO slave. It routes each transaction to one slave, guarantees single-cycle valid pulses toward slaves whose `ready` is a registered copy of `valid`, and terminates unmapped or hung accesses with an error response. It is the stage directly upstream of the shared RAM's RISC-V port.

## Interface
- `RAM_ADDR_WIDTH`, 6: shared RAM word-address width; RAM occupies bytes `0x0000_0000` to `(4<<RAM_ADDR_WIDTH)-1`.
- `IO_BASE`, `32'h1000_0000`: base of the 64 KiB IO window (`mem_addr[31:16] == IO_BASE[31:16]`).
- `TIMEOUT`, 16: cycles a selected slave may withhold ready before error termination; range 2..255.
- `ERR_DATA`, `32'hDEAD_BEEF`: read data returned on error termination.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  core request.
- `mem_ready`  out  1  one-cycle completion pulse to core.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes; 0 = read.
- `mem_rdata`  out  32  read data, valid while `mem_ready`.
- `ram_valid`, `ram_ready`, `ram_addr[RAM_ADDR_WIDTH-1:0]`, `ram_wdata[31:0]`, `ram_wstrb[3:0]`, `ram_rdata[31:0]`: shared RAM port (out, in, out, out, out, in).
- `io_valid`, `io_ready`, `io_addr[15:0]`, `io_wdata[31:0]`, `io_wstrb[3:0]`, `io_rdata[31:0]`: IO port (same directions).
- `err_clr`  in  1  clears the error capture.
- `err_irq`  out  1  sticky bus-error flag.
- `err_addr`  out  32  address of first faulting access.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: on `mem_valid`, decode `mem_addr` (target RAM, IO or NONE) and register target; go to ACCESS. Address, wdata and wstrb are forwarded combinationally from the core; the core holds them stable until `mem_ready`.
- ACCESS: selected slave's valid high, the other low. On the selected slave's ready: `mem_ready` = 1 for one cycle, `mem_rdata` = slave rdata; go to DONE. Target NONE: respond on the first ACCESS cycle with `ERR_DATA`, flag error; writes have no effect.
- Timeout counter (8 bits) clears on entering ACCESS and increments each ACCESS cycle without ready; at count == `TIMEOUT` the block completes with `ERR_DATA`, flags error, goes to DONE. Slave ready and timeout in the same cycle: slave wins, no error.
- DONE: all slave valids low for exactly one cycle, which masks the repeat ready pulse of registered-ready slaves; then IDLE. Slave ready is ignored outside ACCESS.
- `mem_rdata` = 0 when `mem_ready` = 0.
- Address outside RAM size, even with upper bits zero, is target NONE.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, all slave valids 0, `err_irq`=0, `err_addr`=0, FSM=IDLE, counter=0.
- RAM read/write: `mem_valid` at cycle 0 -> `ram_valid` cycles 1..2 -> `mem_ready` cycle 2 (3-cycle transaction, plus DONE).
- Unmapped: `mem_ready` at cycle 1.
- Hung slave: `mem_ready` at cycle `TIMEOUT`+1.
- Back-to-back: next request accepted in the cycle after DONE.
- Reset mid-transaction: immediate return to reset values; no completion emitted.

## Configuration
- `RV_BUS_ERR_CAPTURE_EN` defined: on first error while `err_irq`=0, set `err_irq` and capture `err_addr`; later errors do not overwrite. `err_clr` clears both next cycle and takes priority over a simultaneous new error.
- Undefined: `err_irq`, `err_addr` tied 0, `err_clr` ignored; error responses (`ERR_DATA`, timeout) unchanged.

## Structure
- Shared package `rv_bus_pkg`: target encoding (RAM, IO, NONE), FSM state encoding, default `ERR_DATA`, IO window size constant.
- Sub-module `rv_bus_timeout`: counter with clear, enable and terminal-count output.

## Test plan
- Write 0x1234_5678, wstrb 4'hF to 0x0000_0010, then read -> `ram_addr`=4, ready at cycle 2, rdata 0x1234_5678.
- Read 0x2000_0000 -> `mem_ready` cycle 1, rdata 0xDEAD_BEEF, `err_irq`=1, `err_addr`=0x2000_0000.
- IO read with `io_ready` held 0, `TIMEOUT`=16 -> `mem_ready` at cycle 17 with 0xDEAD_BEEF; the following `err_clr` -> `err_irq`=0.
- Registered-ready RAM model, two consecutive reads -> exactly two `mem_ready` pulses, `ram_valid` low during DONE.
- `io_ready` rises in the same cycle the count reaches `TIMEOUT` -> io_rdata returned, `err_irq` stays 0.
- Drop `resetn` during ACCESS -> all outputs at reset values, no `mem_ready`; after release a fresh read completes normally.

Source files
------------

// File: rtl/rv_bus_pkg.sv
// Shared types and constants for the RISC-V bus fabric: slave target encoding,
// sequencer FSM states and default error response.
package rv_bus_pkg;

    typedef enum logic [1:0] {
        TgtNone = 2'd0,
        TgtRam  = 2'd1,
        TgtIo   = 2'd2
    } target_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic [31:0] ErrDataDefault = 32'hDEAD_BEEF;
    localparam int unsigned IoWindowBytes  = 65536;
    localparam int unsigned TimeoutWidth   = 8;

endpackage

// File: rtl/rv_bus_timeout.sv
// Access watchdog: counts stalled cycles of the current access and flags when
// the count reaches the configured limit.
module rv_bus_timeout
    import rv_bus_pkg::*;
#(
    parameter int unsigned Limit = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TimeoutWidth-1:0] LimitVal = TimeoutWidth'(Limit);

    logic [TimeoutWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LimitVal);

endmodule

// File: rtl/rv_bus_fabric.sv
// Core-bus decoder/sequencer routing to shared RAM or IO, with error termination.
// Optional error capture (err_irq/err_addr) enabled by define RV_BUS_ERR_CAPTURE_EN.
module rv_bus_fabric
    import rv_bus_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 6,
    parameter logic [31:0] IO_BASE        = 32'h1000_0000,
    parameter int unsigned TIMEOUT        = 16,
    parameter logic [31:0] ERR_DATA       = ErrDataDefault
) (
    input  logic                      clk,
    input  logic                      resetn,

    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic [3:0]                mem_wstrb,
    output logic [31:0]               mem_rdata,

    output logic                      ram_valid,
    input  logic                      ram_ready,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]               ram_wdata,
    output logic [3:0]                ram_wstrb,
    input  logic [31:0]               ram_rdata,

    output logic                      io_valid,
    input  logic                      io_ready,
    output logic [15:0]               io_addr,
    output logic [31:0]               io_wdata,
    output logic [3:0]                io_wstrb,
    input  logic [31:0]               io_rdata,

    input  logic                      err_clr,
    output logic                      err_irq,
    output logic [31:0]               err_addr
);

    localparam logic [32:0]  RamBytes = 33'(4) << RAM_ADDR_WIDTH;
    localparam int unsigned  IoAw     = $clog2(IoWindowBytes);

    state_e  state_q, state_d;
    target_e target_q, target_d, target_dec;
    logic    sel_ready, expired, complete, err_event;
    logic    in_access;

    // RAM wins by address range only; upper-zero addresses past its end fall to NONE.
    always_comb begin
        target_dec = TgtNone;
        if ({1'b0, mem_addr} < RamBytes) begin
            target_dec = TgtRam;
        end else if (mem_addr[31:IoAw] == IO_BASE[31:IoAw]) begin
            target_dec = TgtIo;
        end
    end

    assign in_access = (state_q == StAccess);

    always_comb begin
        sel_ready = 1'b0;
        unique case (target_q)
            TgtRam:  sel_ready = ram_ready;
            TgtIo:   sel_ready = io_ready;
            default: sel_ready = 1'b0;
        endcase
    end

    // A slave ready in the terminal-count cycle still completes without error.
    assign complete  = in_access && ((target_q == TgtNone) || sel_ready || expired);
    assign err_event = in_access && !sel_ready && ((target_q == TgtNone) || expired);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    target_d = target_dec;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                if (complete) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            target_q <= TgtNone;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    rv_bus_timeout #(
        .Limit (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (!in_access),
        .en      (in_access && !sel_ready),
        .expired (expired)
    );

    assign ram_valid = in_access && (target_q == TgtRam);
    assign io_valid  = in_access && (target_q == TgtIo);
    assign mem_ready = complete;

    always_comb begin
        mem_rdata = '0;
        if (complete) begin
            if (err_event) begin
                mem_rdata = ERR_DATA;
            end else if (target_q == TgtRam) begin
                mem_rdata = ram_rdata;
            end else begin
                mem_rdata = io_rdata;
            end
        end
    end

    assign ram_addr  = mem_addr[RAM_ADDR_WIDTH+1:2];
    assign ram_wdata = mem_wdata;
    assign ram_wstrb = mem_wstrb;
    assign io_addr   = mem_addr[IoAw-1:0];
    assign io_wdata  = mem_wdata;
    assign io_wstrb  = mem_wstrb;

`ifdef RV_BUS_ERR_CAPTURE_EN
    logic        err_irq_q;
    logic [31:0] err_addr_q;

    // Only the first fault is kept until software clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else if (err_clr) begin
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else if (err_event && !err_irq_q) begin
            err_irq_q  <= 1'b1;
            err_addr_q <= mem_addr;
        end
    end

    assign err_irq  = err_irq_q;
    assign err_addr = err_addr_q;
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
    assign err_irq        = 1'b0;
    assign err_addr       = '0;
`endif

endmodule

// File: tb/tb_rv_bus_fabric.sv
// Directed self-checking bench for rv_bus_fabric with a registered-ready RAM model
// and a bench-driven IO slave.
module tb_rv_bus_fabric;

    localparam bit Cap =
`ifdef RV_BUS_ERR_CAPTURE_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        ram_valid, ram_ready;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_wstrb;
    logic        io_valid, io_ready;
    logic [15:0] io_addr;
    logic [31:0] io_wdata, io_rdata;
    logic [3:0]  io_wstrb;
    logic        err_clr, err_irq;
    logic [31:0] err_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulses = 0;

    rv_bus_fabric dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .ram_valid (ram_valid),
        .ram_ready (ram_ready),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wstrb (ram_wstrb),
        .ram_rdata (ram_rdata),
        .io_valid  (io_valid),
        .io_ready  (io_ready),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_wstrb  (io_wstrb),
        .io_rdata  (io_rdata),
        .err_clr   (err_clr),
        .err_irq   (err_irq),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared RAM port model: ready is a registered copy of valid.
    logic [31:0] mem [64];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_ready <= 1'b0;
        end else begin
            ram_ready <= ram_valid;
            if (ram_valid) begin
                ram_rdata <= mem[ram_addr];
                for (int b = 0; b < 4; b++) begin
                    if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_ready === 1'b1) n_pulses <= n_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request at posedge+1 (cycle 0) and returns the cycle index of mem_ready.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int io_at, output int cyc, output logic [31:0] rd,
                          output logic rv1, output logic iv1, output logic [5:0] ra1,
                          output logic [15:0] ia1);
        int  c;
        bit  got;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        mem_valid = 1'b1;
        c = 0; got = 0; cyc = -1; rd = '0;
        rv1 = 1'bx; iv1 = 1'bx; ra1 = 'x; ia1 = 'x;
        while (!got && c < 40) begin
            if (c == io_at) io_ready = 1'b1;
            @(negedge clk);
            if (c == 1) begin
                rv1 = ram_valid; iv1 = io_valid; ra1 = ram_addr; ia1 = io_addr;
            end
            if (mem_ready === 1'b1) begin
                got = 1; cyc = c; rd = mem_rdata;
            end
            @(posedge clk); #1;
            c++;
        end
        mem_valid = 1'b0;
        io_ready  = 1'b0;
    endtask

    task automatic finish_done(input string tag);
        @(negedge clk);
        check({tag, "_done_ram_valid"}, 32'(ram_valid), 32'd0);
        check({tag, "_done_io_valid"}, 32'(io_valid), 32'd0);
        check({tag, "_done_mem_ready"}, 32'(mem_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    int          cyc, p0;
    logic [31:0] rd;
    logic        rv1, iv1;
    logic [5:0]  ra1;
    logic [15:0] ia1;

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        io_ready = 1'b0; io_rdata = 32'hCAFE_F00D; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_ram_valid", 32'(ram_valid), 32'd0);
        check("rst_io_valid", 32'(io_valid), 32'd0);
        check("rst_err_irq", 32'(err_irq), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // RAM write then read back
        do_txn(32'h0000_0010, 32'h1234_5678, 4'hF, -1, cyc, rd, rv1, iv1, ra1, ia1);
        check("wr_cycle", cyc, 32'd2);
        check("wr_ram_valid", 32'(rv1), 32'd1);
        check("wr_io_valid", 32'(iv1), 32'd0);
        check("wr_ram_addr", 32'(ra1), 32'd4);
        finish_done("wr");

        p0 = n_pulses;
        do_txn(32'h0000_0010, 32'h0, 4'h0, -1, cyc, rd, rv1, iv1, ra1, ia1);
        check("rd1_cycle", cyc, 32'd2);
        check("rd1_data", rd, 32'h1234_5678);
        finish_done("rd1");
        do_txn(32'h0000_0010, 32'h0, 4'h0, -1, cyc, rd, rv1, iv1, ra1, ia1);
        check("rd2_cycle", cyc, 32'd2);
        check("rd2_data", rd, 32'h1234_5678);
        finish_done("rd2");
        check("b2b_pulses", n_pulses - p0, 32'd2);

        // Last RAM word
        do_txn(32'h0000_00FC, 32'h0BAD_CAFE, 4'hF, -1, cyc, rd, rv1, iv1, ra1, ia1);
        check("top_wr_cycle", cyc, 32'd2);
        check("top_wr_addr", 32'(ra1), 32'd63);
        finish_done("top_wr");
        do_txn(32'h0000_00FC, 32'h0, 4'h0, -1, cyc, rd, rv1, iv1, ra1, ia1);
        check("top_rd_data", rd, 32'h0BAD_CAFE);
        finish_done("top_rd");

        // Unmapped accesses
        do_txn(32'h2000_0000, 32'h0, 4'h0, -1, cyc, rd, rv1, iv1, ra1, ia1);
        check("unm_cycle", cyc, 32'd1);
        check("unm_data", rd, 32'hDEAD_BEEF);
        check("unm_ram_valid", 32'(rv1), 32'd0);
        check("unm_io_valid", 32'(iv1), 32'd0);
        finish_done("unm");
        check("unm_err_irq", 32'(err_irq), Cap ? 32'd1 : 32'd0);
        check("unm_err_addr", err_addr, Cap ? 32'h2000_0000 : 32'd0);

        do_txn(32'h0000_0100, 32'h5555_5555, 4'hF, -1, cyc, rd, rv1, iv1, ra1, ia1);
        check("past_ram_cycle", cyc, 32'd1);
        check("past_ram_data", rd, 32'hDEAD_BEEF);
        check("past_ram_valid", 32'(rv1), 32'd0);
        finish_done("past_ram");
        check("keep_err_addr", err_addr, Cap ? 32'h2000_0000 : 32'd0);

        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("clr_err_irq", 32'(err_irq), 32'd0);
        check("clr_err_addr", err_addr, 32'd0);

        // Clear takes priority over a simultaneous fault
        err_clr = 1'b1;
        do_txn(32'h2000_0004, 32'h0, 4'h0, -1, cyc, rd, rv1, iv1, ra1, ia1);
        err_clr = 1'b0;
        check("prio_cycle", cyc, 32'd1);
        finish_done("prio");
        check("prio_err_irq", 32'(err_irq), 32'd0);

        // Hung IO slave
        do_txn(32'h1000_0004, 32'h0, 4'h0, -1, cyc, rd, rv1, iv1, ra1, ia1);
        check("hung_cycle", cyc, 32'd17);
        check("hung_data", rd, 32'hDEAD_BEEF);
        check("hung_io_valid", 32'(iv1), 32'd1);
        check("hung_io_addr", 32'(ia1), 32'd4);
        finish_done("hung");
        check("hung_err_irq", 32'(err_irq), Cap ? 32'd1 : 32'd0);
        check("hung_err_addr", err_addr, Cap ? 32'h1000_0004 : 32'd0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("hung_clr_irq", 32'(err_irq), 32'd0);

        // IO slave responding normally, then exactly at the terminal count
        do_txn(32'h1000_0008, 32'h0, 4'h0, 3, cyc, rd, rv1, iv1, ra1, ia1);
        check("io_cycle", cyc, 32'd3);
        check("io_data", rd, 32'hCAFE_F00D);
        finish_done("io");
        do_txn(32'h1000_000C, 32'h0, 4'h0, 17, cyc, rd, rv1, iv1, ra1, ia1);
        check("edge_cycle", cyc, 32'd17);
        check("edge_data", rd, 32'hCAFE_F00D);
        finish_done("edge");
        check("edge_err_irq", 32'(err_irq), 32'd0);

        // Reset during ACCESS
        mem_addr = 32'h0000_0010; mem_wstrb = 4'h0; mem_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_pre_valid", 32'(ram_valid), 32'd1);
        p0 = n_pulses;
        #1 resetn = 1'b0;
        #1;
        check("mid_mem_ready", 32'(mem_ready), 32'd0);
        check("mid_mem_rdata", mem_rdata, 32'd0);
        check("mid_ram_valid", 32'(ram_valid), 32'd0);
        check("mid_io_valid", 32'(io_valid), 32'd0);
        mem_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        check("mid_no_pulse", n_pulses - p0, 32'd0);
        do_txn(32'h0000_0010, 32'h0, 4'h0, -1, cyc, rd, rv1, iv1, ra1, ia1);
        check("post_rst_cycle", cyc, 32'd2);
        check("post_rst_data", rd, 32'h1234_5678);
        finish_done("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
